// File: rtl/psk_carrier_mod_if.sv
// Symbol handshake between the bit/symbol source and the carrier modulator.
//   sym       : 2-bit symbol (BPSK uses sym[0] only)
//   sym_valid : source presents a symbol this cycle
//   sym_ready : modulator accepts the symbol this cycle
// master = symbol source, slave = modulator.
interface psk_carrier_mod_if;
  logic [1:0] sym;
  logic       sym_valid;
  logic       sym_ready;

  modport master (output sym, output sym_valid, input sym_ready);
  modport slave  (input sym, input sym_valid, output sym_ready);
endinterface

// File: rtl/psk_carrier_mod.sv
// BPSK/QPSK carrier modulator. Takes symbols over a valid/ready handshake and
// emits one signed I and one signed Q carrier sample per enabled clock. The
// carrier phase is chosen from the symbol and only changes at symbol
// boundaries. Back-to-back symbols are seamless; a missing follow-up symbol
// returns the block to IDLE with an underrun pulse.
// Ports:
//   clk       : sample clock, rising edge
//   reset     : asynchronous, active-low; clears all state and outputs
//   en        : sample enable; 0 freezes everything
//   s_sym     : symbol handshake (slave side)
//   i_out     : registered in-phase sample
//   q_out     : registered quadrature sample (0 in BPSK)
//   busy      : 1 while in RUN
//   sym_start : 1-cycle pulse with the first sample of each symbol
//   underrun  : 1-cycle pulse when a symbol ends with no successor
module psk_carrier_mod #(
  parameter int OUT_W       = 8,
  parameter int N           = 52,
  parameter int AMPL        = 78,
  parameter int CYC_PER_SYM = 1,
  parameter int QPSK        = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  psk_carrier_mod_if.slave        s_sym,
  output logic signed [OUT_W-1:0] i_out,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    busy,
  output logic                    sym_start,
  output logic                    underrun
);
  localparam int IDX_W = $clog2(N);
  localparam int CYC_W = (CYC_PER_SYM > 1) ? $clog2(CYC_PER_SYM) : 1;
  localparam int SUM_W = IDX_W + 2;

  typedef enum logic {IDLE, RUN} state_t;

  // Round-half-away-from-zero of AMPL*cos(2*pi*k/N), evaluated at elaboration.
  function automatic logic signed [OUT_W-1:0] round_cos(input int k);
    real v;
    v = real'(AMPL) * $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(N));
    if (v >= 0.0) return OUT_W'($rtoi(v + 0.5));
    else          return OUT_W'(-$rtoi(0.5 - v));
  endfunction

  // Phase offset in LUT steps; QPSK uses Gray mapping.
  function automatic logic [IDX_W-1:0] sym_off(input logic [1:0] s);
    if (QPSK == 0) return s[0] ? '0 : IDX_W'(N / 2);
    case (s)
      2'b00:   return '0;
      2'b01:   return IDX_W'(N / 4);
      2'b11:   return IDX_W'(N / 2);
      default: return IDX_W'(3 * N / 4);
    endcase
  endfunction

  // Operands are always < 2N, so a single conditional subtract wraps them.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [SUM_W-1:0] s);
    if (s >= SUM_W'(N)) return IDX_W'(s - SUM_W'(N));
    return IDX_W'(s);
  endfunction

  logic signed [OUT_W-1:0] w_lut [N];
  for (genvar g = 0; g < N; g++) begin : g_lut
    localparam logic signed [OUT_W-1:0] LV = round_cos(g);
    assign w_lut[g] = LV;
  end

  state_t                  r_state, w_state_nxt;
  logic [IDX_W-1:0]        r_off;
  logic [IDX_W-1:0]        r_k;
  logic [CYC_W-1:0]        r_cyc;
  logic signed [OUT_W-1:0] r_i, r_q;
  logic                    r_sym_start, r_underrun;

  logic                    w_last, w_ready, w_load, w_step, w_stop;
  logic [IDX_W-1:0]        w_new_off, w_k_nxt, w_base_k, w_base_off;
  logic [IDX_W-1:0]        w_i_idx, w_q_idx;

  // r_k/r_cyc address the sample currently on the outputs.
  assign w_last = (r_state == RUN) && (r_k == IDX_W'(N - 1)) &&
                  (r_cyc == CYC_W'(CYC_PER_SYM - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_stop      = 1'b0;
    if (en) begin
      case (r_state)
        IDLE: begin
          w_ready = 1'b1;
          if (s_sym.sym_valid) begin
            w_load      = 1'b1;
            w_state_nxt = RUN;
          end
        end
        RUN: begin
          if (w_last) begin
            w_ready = 1'b1;
            if (s_sym.sym_valid) begin
              w_load = 1'b1;
            end else begin
              w_stop      = 1'b1;
              w_state_nxt = IDLE;
            end
          end else begin
            w_step = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign s_sym.sym_ready = w_ready;

  // A newly loaded symbol starts at k=0 with its own offset, so the first
  // sample is produced on the acceptance edge (one-cycle latency).
  assign w_new_off  = sym_off(s_sym.sym);
  assign w_k_nxt    = (r_k == IDX_W'(N - 1)) ? '0 : r_k + 1'b1;
  assign w_base_k   = w_load ? '0 : w_k_nxt;
  assign w_base_off = w_load ? w_new_off : r_off;
  assign w_i_idx    = wrap_idx(SUM_W'(w_base_k) + SUM_W'(w_base_off));
  assign w_q_idx    = wrap_idx(SUM_W'(w_base_k) + SUM_W'(w_base_off) + SUM_W'(N / 4));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_off       <= '0;
      r_k         <= '0;
      r_cyc       <= '0;
      r_i         <= '0;
      r_q         <= '0;
      r_sym_start <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_sym_start <= 1'b0;
      r_underrun  <= 1'b0;
      if (w_load) begin
        r_off       <= w_new_off;
        r_k         <= '0;
        r_cyc       <= '0;
        r_i         <= w_lut[w_i_idx];
        r_q         <= (QPSK != 0) ? w_lut[w_q_idx] : '0;
        r_sym_start <= 1'b1;
      end else if (w_step) begin
        r_k <= w_k_nxt;
        if (r_k == IDX_W'(N - 1)) r_cyc <= r_cyc + 1'b1;
        r_i <= w_lut[w_i_idx];
        r_q <= (QPSK != 0) ? w_lut[w_q_idx] : '0;
      end else if (w_stop) begin
        r_k        <= '0;
        r_cyc      <= '0;
        r_i        <= '0;
        r_q        <= '0;
        r_underrun <= 1'b1;
      end
    end
  end

  assign i_out     = r_i;
  assign q_out     = r_q;
  assign busy      = (r_state == RUN);
  // Pulses are masked while the sample clock is disabled.
  assign sym_start = r_sym_start & en;
  assign underrun  = r_underrun & en;
endmodule

// File: tb/tb_psk_carrier_mod.sv
module tb_psk_carrier_mod;
  logic clk = 1'b0;
  logic reset;
  logic en;
  always #5 clk = ~clk;

  psk_carrier_mod_if bif ();
  psk_carrier_mod_if qif ();

  logic signed [7:0] bi, bq, qi, qq;
  logic bbusy, bss, bur, qbusy, qss, qur;

  psk_carrier_mod u_bpsk (
    .clk(clk), .reset(reset), .en(en), .s_sym(bif),
    .i_out(bi), .q_out(bq), .busy(bbusy), .sym_start(bss), .underrun(bur)
  );

  psk_carrier_mod #(.QPSK(1)) u_qpsk (
    .clk(clk), .reset(reset), .en(en), .s_sym(qif),
    .i_out(qi), .q_out(qq), .busy(qbusy), .sym_start(qss), .underrun(qur)
  );

  typedef struct {
    int cyc;
    int ei;
    int eq;
    int ess;
    int eur;
  } vec_t;

  int n_tot = 0;
  int n_bad = 0;
  int cap_i [0:127];
  int cap_q [0:127];
  int cap_ss [0:127];
  int cap_ur [0:127];
  int cap_busy [0:127];
  int cap_rdy [0:127];

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs, then record cycle n of the BPSK instance.
  task automatic cap_b(input int n);
    #1;
    cap_i[n]    = int'(bi);
    cap_q[n]    = int'(bq);
    cap_ss[n]   = int'(bss);
    cap_ur[n]   = int'(bur);
    cap_busy[n] = int'(bbusy);
    cap_rdy[n]  = int'(bif.sym_ready);
  endtask

  task automatic chk_vec(input string nm, input vec_t v);
    chk($sformatf("%s i@%0d", nm, v.cyc), cap_i[v.cyc], v.ei);
    chk($sformatf("%s q@%0d", nm, v.cyc), cap_q[v.cyc], v.eq);
    chk($sformatf("%s sym_start@%0d", nm, v.cyc), cap_ss[v.cyc], v.ess);
    chk($sformatf("%s underrun@%0d", nm, v.cyc), cap_ur[v.cyc], v.eur);
  endtask

  vec_t tv1 [9];
  vec_t tv2 [8];
  vec_t tv5 [7];

  initial begin
    int nz;
    int urc;

    reset = 1'b0;
    en = 1'b1;
    bif.sym = 2'b00; bif.sym_valid = 1'b0;
    qif.sym = 2'b00; qif.sym_valid = 1'b0;

    tv1 = '{'{1, 78, 0, 1, 0}, '{2, 77, 0, 0, 0}, '{13, 9, 0, 0, 0},
            '{14, 0, 0, 0, 0}, '{26, -77, 0, 0, 0}, '{27, -78, 0, 0, 0},
            '{52, 77, 0, 0, 0}, '{53, 0, 0, 0, 1}, '{54, 0, 0, 0, 0}};
    tv2 = '{'{1, 78, 0, 1, 0}, '{27, -78, 0, 0, 0}, '{52, 77, 0, 0, 0},
            '{53, -78, 0, 1, 0}, '{54, -77, 0, 0, 0}, '{79, 78, 0, 0, 0},
            '{104, -77, 0, 0, 0}, '{105, 0, 0, 0, 1}};
    tv5 = '{'{27, -78, 0, 0, 0}, '{30, -78, 0, 0, 0}, '{32, -78, 0, 0, 0},
            '{33, -77, 0, 0, 0}, '{58, 77, 0, 0, 0}, '{59, 77, 0, 0, 0},
            '{60, 0, 0, 0, 1}};

    // Reset state
    tick(); tick();
    chk("rst i_out", int'(bi), 0);
    chk("rst q_out", int'(bq), 0);
    chk("rst busy", int'(bbusy), 0);
    chk("rst sym_start", int'(bss), 0);
    chk("rst underrun", int'(bur), 0);
    reset = 1'b1;
    tick(); #1;
    chk("idle sym_ready", int'(bif.sym_ready), 1);

    // Single BPSK symbol '1' followed by underrun
    bif.sym = 2'b01; bif.sym_valid = 1'b1;
    #1;
    chk("t1 ready at accept", int'(bif.sym_ready), 1);
    for (int n = 1; n <= 54; n++) begin
      tick();
      bif.sym_valid = 1'b0;
      cap_b(n);
    end
    foreach (tv1[j]) chk_vec("t1", tv1[j]);
    nz = 0;
    for (int n = 1; n <= 53; n++) if (cap_q[n] != 0) nz++;
    chk("t1 bpsk q nonzero count", nz, 0);
    chk("t1 busy@52", cap_busy[52], 1);
    chk("t1 busy@53", cap_busy[53], 0);
    chk("t1 ready after underrun", cap_rdy[54], 1);

    // Back-to-back BPSK: 1 then 0, with sym changed while the first plays
    tick();
    bif.sym = 2'b01; bif.sym_valid = 1'b1;
    for (int n = 1; n <= 106; n++) begin
      tick();
      if (n == 1) bif.sym = 2'b00;
      if (n == 53) bif.sym_valid = 1'b0;
      cap_b(n);
    end
    foreach (tv2[j]) chk_vec("t2", tv2[j]);
    chk("t2 ready@51", cap_rdy[51], 0);
    chk("t2 ready@52", cap_rdy[52], 1);
    urc = 0;
    for (int n = 1; n <= 104; n++) urc += cap_ur[n];
    chk("t2 underrun count", urc, 0);

    // QPSK: 01 then 10 back-to-back
    tick();
    qif.sym = 2'b01; qif.sym_valid = 1'b1;
    tick();
    qif.sym = 2'b10;
    #1;
    chk("t3 01 i first", int'(qi), 0);
    chk("t3 01 q first", int'(qq), -78);
    chk("t3 01 sym_start", int'(qss), 1);
    tick(); #1;
    chk("t3 01 i second", int'(qi), -9);
    chk("t3 01 q second", int'(qq), -77);
    for (int n = 3; n <= 53; n++) tick();
    qif.sym_valid = 1'b0;
    #1;
    chk("t3 10 i first", int'(qi), 0);
    chk("t3 10 q first", int'(qq), 78);
    chk("t3 10 sym_start", int'(qss), 1);
    for (int n = 54; n <= 106; n++) tick();
    #1;
    chk("t3 qpsk back to idle", int'(qbusy), 0);

    // Enable freeze mid-symbol and on the last sample
    tick();
    bif.sym = 2'b01; bif.sym_valid = 1'b1;
    for (int n = 1; n <= 62; n++) begin
      tick();
      if ((n >= 27 && n <= 31) || n == 57 || n == 58) begin
        en = 1'b0; bif.sym = 2'b00; bif.sym_valid = 1'b1;
      end else begin
        en = 1'b1; bif.sym_valid = 1'b0;
      end
      cap_b(n);
    end
    foreach (tv5[j]) chk_vec("t5", tv5[j]);
    chk("t5 ready frozen mid", cap_rdy[28], 0);
    chk("t5 ready frozen last", cap_rdy[57], 0);
    chk("t5 ready after thaw", cap_rdy[59], 1);
    chk("t5 busy after underrun", cap_busy[60], 0);

    // Asynchronous reset mid-symbol
    tick();
    bif.sym = 2'b01; bif.sym_valid = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      tick();
      bif.sym_valid = 1'b0;
    end
    #1;
    chk("t6 busy before reset", int'(bbusy), 1);
    reset = 1'b0;
    #1;
    chk("t6 i_out async", int'(bi), 0);
    chk("t6 busy async", int'(bbusy), 0);
    tick();
    reset = 1'b1;
    #1;
    chk("t6 ready after release", int'(bif.sym_ready), 1);
    bif.sym = 2'b00; bif.sym_valid = 1'b1;
    tick();
    bif.sym_valid = 1'b0;
    #1;
    chk("t6 first i after reset", int'(bi), -78);
    chk("t6 sym_start after reset", int'(bss), 1);
    chk("t6 q after reset", int'(bq), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
